mips_cpu_muldiv: RTL
====================

Name: mips_cpu_muldiv

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair. It replaces the single-cycle combinational `*`, `/` and `%` paths in the ALU.
- Generalised to a WIDTH-bit datapath with a start/busy/done handshake.
- The control unit issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here. It reads HI/LO directly for MFHI/MFLO and stalls while busy=1.

Parameters:
- WIDTH, 32, operand, HI and LO width (≥4). The iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are no-ops
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- b  in  WIDTH  rt operand (divisor / multiplier)
- busy  out  1  arithmetic op in progress; HI/LO are stale
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (any cycle, including mid-operation): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. An in-flight op is aborted and never writes HI/LO.
- States and transitions:
  - IDLE: on start with op 000–011, latch op, |a|, |b| (magnitudes for signed ops) and the result-sign flags, then go to CALC. Set busy=1 from the next cycle.
  - CALC: exactly WIDTH cycles, one bit per cycle. Multiply uses shift-add into a 2·WIDTH accumulator. Divide uses restoring shift-subtract producing a WIDTH-bit quotient and remainder. Then go to FIX.
  - FIX: one cycle. Apply two's-complement sign correction and write HI/LO. Next cycle: state=IDLE, busy=0, done=1.
- Latency: start accepted at edge E0 → hi/lo updated and done=1 after edge E0+WIDTH+1. busy=1 for exactly WIDTH+1 cycles.
- done: high for exactly one cycle. A new start in the done cycle is accepted (back-to-back ops, no bubble).
- Operand capture: a, b and op are captured at acceptance; later changes have no effect. HI/LO keep their old values until the FIX write.
- MTHI/MTLO: accepted only when busy=0. The named register is written at the next edge; busy and done stay 0. The other register is unchanged.
- start while busy=1: ignored for all ops, including MTHI/MTLO. The CPU must stall.
- Opcodes 110/111: no effect.
- Multiply results:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product.
  - MULT: signed; the product is negated if sign(a)≠sign(b).
- Divide results:
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (b=0):
  - DIVU: lo = all ones, hi = a.
  - DIV: lo = all ones, hi = a (signed value unchanged).
  - Either case still takes the full WIDTH+1 cycles.
- Signed overflow, DIV most-negative / −1: lo = most-negative, hi = 0.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (−3), b=7 → done exactly 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with the same operands → hi=0x00000006, lo=0xFFFFFFEB. busy high for 33 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Idle MTHI a=0xDEADBEEF → hi=0xDEADBEEF next cycle, lo unchanged, busy=done=0. During a MULTU, assert start with MTLO and change a/b every cycle → lo not written, final result matches the originally captured operands.
- reset asserted 10 cycles into a DIV → next cycle busy=0, done=0, hi=lo=0, and no done pulse ever appears. A subsequent MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Back-to-back: start MULTU 3×5 in the done cycle of a prior DIVU → accepted, done 33 cycles later with hi=0, lo=15. Repeat the MULT and DIV cases with WIDTH=8 and WIDTH=16 against a reference model, latency WIDTH+1.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative multiply/divide unit owning HI/LO, one bit per cycle
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, bz, ge;
  logic [W-1:0] opnd, mag_a, mag_b, diff;
  logic [W:0] sum, trial;
  logic [2*W-1:0] acc, acc_nx;
  always_comb begin
    mag_a = (op[0] && a[W-1]) ? -a : a;
    mag_b = (op[0] && b[W-1]) ? -b : b;
    sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    trial = acc[2*W-1:W-1];
    ge = trial >= {1'b0, opnd};
    diff = trial[W-1:0] - opnd;
    acc_nx = is_div ? {ge ? diff : trial[W-1:0], acc[W-2:0], ge} : {sum, acc[W-1:1]};
  end
  // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      opnd <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (!op[2]) begin
            state <= CALC;
            busy <= 1'b1;
            cnt <= '0;
            is_div <= op[1];
            neg_q <= op[0] & (a[W-1] ^ b[W-1]);
            neg_r <= op[0] & a[W-1];
            bz <= b == '0;
            opnd <= op[1] ? mag_b : mag_a;
            acc <= {{W{1'b0}}, op[1] ? mag_a : mag_b};
          end else if (op == 3'b100) hi <= a;
          else if (op == 3'b101) lo <= a;
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            lo <= bz ? '1 : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
            hi <= neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
          end else {hi, lo} <= neg_q ? -acc : acc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
